// File: rtl/store_drain_pkg.sv
// store_drain_pkg: shared types for the store-buffer drain path.
//   store_entry_t : one committed store {addr, data, be}, be in the LSBs
//   drain_state_e : drain FSM states
package store_drain_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned LINE_W = ADDR_W + DATA_W + BE_W;

    // Same layout the store FIFO emits on its head port.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } store_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_e;

endpackage

// File: rtl/store_drain.sv
// store_drain: pops committed stores from the store FIFO head and issues each
// as one req/ack write on the data-memory bus, back-to-back while entries remain.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush             blocks pop/latch in the cycle it is high
//   fifo_head/empty   combinational head of the store FIFO and its empty flag
//   fifo_pop          combinational pop strobe (same edge as the latch)
//   bus_req/addr/wdata/be, bus_ack   write request channel
//   idle              nothing in flight and FIFO empty
//   drain_count       completed writes, wraps modulo 2^32
module store_drain
    import store_drain_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    localparam int unsigned LINE_WIDTH = ADDR_WIDTH + DATA_WIDTH + BE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [LINE_WIDTH-1:0] fifo_head,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    output logic                  bus_req,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [BE_WIDTH-1:0]   bus_be,
    input  logic                  bus_ack,
    output logic                  idle,
    output logic [31:0]           drain_count
);

    drain_state_e          state_q, state_d;
    logic [LINE_WIDTH-1:0] entry_q, entry_d;
    logic [31:0]           count_q, count_d;
    logic                  take;

    assign take = ~fifo_empty & ~flush;

    // State, entry and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            entry_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

    // Next state: the entry register reloads on every pop, so a pop in REQ
    // chains straight into the next request without an idle cycle.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (take) state_d = REQ;
            end
            REQ: begin
                if (bus_ack) begin
                    count_d = count_q + 32'd1;
                    if (!take) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fifo_pop) entry_d = fifo_head;
    end

    // Outputs: pop whenever the engine can accept a new entry this cycle.
    always_comb begin
        fifo_pop = 1'b0;
        bus_req  = 1'b0;
        idle     = 1'b0;
        unique case (state_q)
            IDLE: begin
                fifo_pop = take;
                idle     = fifo_empty;
            end
            REQ: begin
                bus_req  = 1'b1;
                fifo_pop = bus_ack & take;
            end
            default: ;
        endcase
    end

    // Entry register shown on the bus regardless of state.
    assign bus_addr    = entry_q[LINE_WIDTH-1 -: ADDR_WIDTH];
    assign bus_wdata   = entry_q[BE_WIDTH +: DATA_WIDTH];
    assign bus_be      = entry_q[BE_WIDTH-1:0];
    assign drain_count = count_q;

endmodule
